upstream_memory_controller: RTL and testbench
=============================================

UPSTREAM_MEMORY_CONTROLLER -- requirements
Module: upstream_memory_controller

Parameters
REQ-001 SHALL have parameter ADDR_W, default 4, memory address width (depth 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, memory word width.
REQ-003 SHALL have parameter LATENCY, default 2, number of ACCESS-state cycles, legal range 1..15.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum NOTIFY-state cycles before abort, legal range 1..255.

Interface
REQ-005 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port: req  in  1  upstream request, sampled only in IDLE.
REQ-008 SHALL have port: wr  in  1  1 = write, 0 = read; captured with req.
REQ-009 SHALL have port: addr  in  ADDR_W  word address; captured with req.
REQ-010 SHALL have port: wdata  in  DATA_W  write data; captured with req.
REQ-011 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port: rdata  out  DATA_W  read result, held until the next read commit.
REQ-013 SHALL have port: rvalid  out  1  one-cycle pulse when rdata updates.
REQ-014 SHALL have port: ack  out  1  drives ack of downstream_processor.
REQ-015 SHALL have port: memwr  out  1  drives memwr of downstream_processor; equals captured wr while ack=1, else 0.
REQ-016 SHALL have port: ds_out  in  1  out of downstream_processor; downstream acceptance indication.
REQ-017 SHALL have port: err  out  1  sticky NOTIFY-timeout flag.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCESS, NOTIFY and RELEASE, with all outputs registered.
REQ-019 SHALL, when in IDLE with req=1 at an edge, capture wr, addr and wdata, enter ACCESS and set busy=1.
REQ-020 SHALL, when in IDLE with req=0, remain in IDLE.
REQ-021 SHALL ignore req in all states other than IDLE, with no queueing.
REQ-022 SHALL remain in ACCESS for exactly LATENCY edges, using a cycle counter that wraps to 0 on exit.
REQ-023 SHALL, on the final ACCESS edge for a write, write mem[addr] <= wdata.
REQ-024 SHALL, on the final ACCESS edge for a read, load rdata <= mem[addr] and pulse rvalid=1 for exactly one cycle.
REQ-025 SHALL, on the final ACCESS edge, enter NOTIFY and set ack=1 and memwr=wr.
REQ-026 SHALL therefore raise ack LATENCY+1 edges after req is sampled (3 edges at default).
REQ-027 SHALL, in NOTIFY, hold ack and memwr constant while ds_out=0.
REQ-028 SHALL, in NOTIFY with ds_out=1 at an edge, enter RELEASE and set ack=0 and memwr=0.
REQ-029 SHALL count NOTIFY cycles in an 8-bit counter.
REQ-030 SHALL, if TIMEOUT edges elapse in NOTIFY without ds_out=1, enter IDLE, set ack=0, memwr=0 and busy=0, and set err=1.
REQ-031 SHALL give ds_out=1 priority when it coincides with the timeout edge: enter RELEASE and leave err unchanged.
REQ-032 SHALL, in RELEASE, remain while ds_out=1.
REQ-033 SHALL, in RELEASE with ds_out=0 at an edge, enter IDLE and set busy=0.
REQ-034 SHALL allow a new req to be sampled on the first IDLE edge after RELEASE exits.
REQ-035 SHALL allow a read of the address just written to return the new data, since there is no bypass hazard with one operation in flight.
REQ-036 SHALL compute address arithmetic modulo 2**ADDR_W, with no out-of-range addresses.

Reset
REQ-037 SHALL, on rst=1 at an edge, force state IDLE and set busy, ack, memwr, rvalid and err to 0, rdata to 0 and all counters to 0.
REQ-038 SHALL give rst priority over every other input, including mid-ACCESS and mid-NOTIFY.
REQ-039 SHALL make an aborted write not modify memory unless its commit edge already passed.
REQ-040 SHALL not reset the memory array: contents are retained across rst and undefined after power-up.
REQ-041 SHALL clear err only by rst.

Verification
REQ-042 SHALL cover: rst, then req=1, wr=1, addr=3, wdata=A5 for 1 cycle -> busy=1 next edge; ack=1, memwr=1 at edge 3; hold ds_out=0 -> ack stays 1.
REQ-043 SHALL cover: continuing REQ-042, ds_out=1 -> ack=0, memwr=0 next edge; ds_out=0 -> busy=0 next edge; err=0.
REQ-044 SHALL cover: req=1, wr=0, addr=3 -> at edge 3 rdata=A5, rvalid=1 for one cycle, ack=1, memwr=0.
REQ-045 SHALL cover: read request with ds_out held 0 -> after 15 NOTIFY edges state IDLE, ack=0, busy=0, err=1; err stays 1 until rst.
REQ-046 SHALL cover: req=1 held continuously during an operation -> exactly one operation per IDLE visit; req pulses during ACCESS/NOTIFY produce no extra operation.
REQ-047 SHALL cover: rst asserted on first ACCESS edge of write addr=5, wdata=3C -> all outputs 0 next edge; subsequent read of addr=5 returns its prior value, not 3C.

Source files
------------

// File: rtl/upstream_memory_controller.sv
// Single-outstanding memory access controller: captures an upstream request,
// runs a fixed-latency access, then handshakes the result with a downstream processor.
module upstream_memory_controller #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ack,
  output logic              memwr,
  input  logic              ds_out,
  output logic              err
);

  // state   | meaning
  // IDLE    | waiting for req; only state where req is sampled
  // ACCESS  | LATENCY cycles of memory access; commit on the last one
  // NOTIFY  | ack held until ds_out accepts or the timeout aborts
  // RELEASE | waiting for ds_out to drop before returning to IDLE
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    NOTIFY  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t              state, state_n;
  logic [3:0]          acc_cnt, acc_cnt_n;
  logic [7:0]          ntf_cnt, ntf_cnt_n;
  logic                cap_wr, cap_wr_n;
  logic [ADDR_W-1:0]   cap_addr, cap_addr_n;
  logic [DATA_W-1:0]   cap_wdata, cap_wdata_n;
  logic                busy_n, ack_n, memwr_n, rvalid_n, err_n;
  logic [DATA_W-1:0]   rdata_n;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  always_comb begin
    state_n     = state;
    acc_cnt_n   = acc_cnt;
    ntf_cnt_n   = ntf_cnt;
    cap_wr_n    = cap_wr;
    cap_addr_n  = cap_addr;
    cap_wdata_n = cap_wdata;
    busy_n      = busy;
    ack_n       = ack;
    memwr_n     = memwr;
    rvalid_n    = 1'b0;
    rdata_n     = rdata;
    err_n       = err;
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_n     = ACCESS;
          cap_wr_n    = wr;
          cap_addr_n  = addr;
          cap_wdata_n = wdata;
          busy_n      = 1'b1;
          acc_cnt_n   = 4'd0;
        end
      end
      ACCESS: begin
        if (acc_cnt == LAT_LAST) begin
          state_n   = NOTIFY;
          acc_cnt_n = 4'd0;
          ntf_cnt_n = 8'd0;
          ack_n     = 1'b1;
          memwr_n   = cap_wr;
          if (cap_wr) begin
            mem_we = 1'b1;
          end else begin
            rdata_n  = mem[cap_addr];
            rvalid_n = 1'b1;
          end
        end else begin
          acc_cnt_n = acc_cnt + 4'd1;
        end
      end
      NOTIFY: begin
        // acceptance wins over a coincident timeout
        if (ds_out) begin
          state_n   = RELEASE;
          ack_n     = 1'b0;
          memwr_n   = 1'b0;
          ntf_cnt_n = 8'd0;
        end else if (ntf_cnt == TO_LAST) begin
          state_n   = IDLE;
          ack_n     = 1'b0;
          memwr_n   = 1'b0;
          busy_n    = 1'b0;
          err_n     = 1'b1;
          ntf_cnt_n = 8'd0;
        end else begin
          ntf_cnt_n = ntf_cnt + 8'd1;
        end
      end
      RELEASE: begin
        if (!ds_out) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_cnt   <= 4'd0;
      ntf_cnt   <= 8'd0;
      cap_wr    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      memwr     <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      acc_cnt   <= acc_cnt_n;
      ntf_cnt   <= ntf_cnt_n;
      cap_wr    <= cap_wr_n;
      cap_addr  <= cap_addr_n;
      cap_wdata <= cap_wdata_n;
      busy      <= busy_n;
      ack       <= ack_n;
      memwr     <= memwr_n;
      rvalid    <= rvalid_n;
      rdata     <= rdata_n;
      err       <= err_n;
    end
  end

  // memory contents survive reset; reset only suppresses a coincident commit
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[cap_addr] <= cap_wdata;
    end
  end

endmodule

// File: tb/tb_upstream_memory_controller.sv
// Directed bench for upstream_memory_controller at default parameters;
// expected values are hand-derived from the cycle-level behaviour.
module tb_upstream_memory_controller;

  logic       clk = 1'b0;
  logic       rst, req, wr, ds_out;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       busy, rvalid, ack, memwr, err;
  logic [7:0] rdata;

  int n_cmp = 0;
  int n_mis = 0;

  upstream_memory_controller dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .rdata(rdata), .rvalid(rvalid), .ack(ack), .memwr(memwr),
    .ds_out(ds_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // full operation with a prompt downstream handshake
  task automatic run_op(input logic w, input logic [3:0] a, input logic [7:0] d);
    req = 1'b1; wr = w; addr = a; wdata = d;
    step(1);
    req = 1'b0;
    step(2);
    check("op_ack", ack, 1);
    ds_out = 1'b1;
    step(1);
    ds_out = 1'b0;
    step(1);
    check("op_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; ds_out = 1'b0; addr = 4'd0; wdata = 8'd0;
    step(2);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_memwr", memwr, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);

    // write A5 to addr 3, slow downstream
    req = 1'b1; wr = 1'b1; addr = 4'd3; wdata = 8'hA5;
    step(1);
    req = 1'b0;
    check("wr_e1_busy", busy, 1);
    check("wr_e1_ack", ack, 0);
    step(1);
    check("wr_e2_ack", ack, 0);
    step(1);
    check("wr_e3_ack", ack, 1);
    check("wr_e3_memwr", memwr, 1);
    step(3);
    check("wr_hold_ack", ack, 1);
    check("wr_hold_memwr", memwr, 1);
    ds_out = 1'b1;
    step(1);
    check("wr_rel_ack", ack, 0);
    check("wr_rel_memwr", memwr, 0);
    check("wr_rel_busy", busy, 1);
    ds_out = 1'b0;
    step(1);
    check("wr_done_busy", busy, 0);
    check("wr_done_err", err, 0);

    // read back addr 3
    req = 1'b1; wr = 1'b0; addr = 4'd3;
    step(1);
    req = 1'b0;
    step(1);
    check("rd_e2_rvalid", rvalid, 0);
    step(1);
    check("rd_e3_rdata", rdata, 8'hA5);
    check("rd_e3_rvalid", rvalid, 1);
    check("rd_e3_ack", ack, 1);
    check("rd_e3_memwr", memwr, 0);
    step(1);
    check("rd_e4_rvalid", rvalid, 0);
    check("rd_e4_rdata", rdata, 8'hA5);
    ds_out = 1'b1; step(1);
    ds_out = 1'b0; step(1);
    check("rd_done_busy", busy, 0);

    // reset on first ACCESS edge aborts the 3C write to addr 5
    run_op(1'b1, 4'd5, 8'h11);
    req = 1'b1; wr = 1'b1; addr = 4'd5; wdata = 8'h3C;
    step(1);
    req = 1'b0; rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ack", ack, 0);
    check("abort_memwr", memwr, 0);
    check("abort_rvalid", rvalid, 0);
    check("abort_rdata", rdata, 0);
    run_op(1'b0, 4'd5, 8'h00);
    check("abort_rd5", rdata, 8'h11);

    // req held high: one operation per IDLE visit
    req = 1'b1; wr = 1'b0; addr = 4'd3;
    step(1);
    check("hold_e1_busy", busy, 1);
    step(2);
    check("hold_e3_rvalid", rvalid, 1);
    step(3);
    check("hold_ntf_rvalid", rvalid, 0);
    check("hold_ntf_ack", ack, 1);
    ds_out = 1'b1; step(1);
    check("hold_rel_busy", busy, 1);
    ds_out = 1'b0; step(1);
    check("hold_idle_busy", busy, 0);
    step(1);
    check("hold_resample_busy", busy, 1);
    req = 1'b0;
    step(2);
    check("hold_op2_rvalid", rvalid, 1);
    ds_out = 1'b1; step(1);
    ds_out = 1'b0; step(1);
    check("hold_op2_idle", busy, 0);
    step(2);
    check("hold_no_queue", busy, 0);

    // NOTIFY timeout after 15 edges
    req = 1'b1; wr = 1'b0; addr = 4'd3;
    step(1);
    req = 1'b0;
    step(2);
    check("to_ack_on", ack, 1);
    step(14);
    check("to_14_ack", ack, 1);
    check("to_14_err", err, 0);
    step(1);
    check("to_15_ack", ack, 0);
    check("to_15_busy", busy, 0);
    check("to_15_err", err, 1);
    run_op(1'b0, 4'd3, 8'h00);
    check("to_err_sticky", err, 1);
    rst = 1'b1; step(1); rst = 1'b0;
    check("to_err_cleared", err, 0);

    // ds_out coinciding with the timeout edge wins
    req = 1'b1; wr = 1'b0; addr = 4'd5;
    step(1);
    req = 1'b0;
    step(2);
    step(14);
    ds_out = 1'b1;
    step(1);
    check("prio_ack", ack, 0);
    check("prio_busy", busy, 1);
    check("prio_err", err, 0);
    ds_out = 1'b0;
    step(1);
    check("prio_idle", busy, 0);
    check("prio_rdata", rdata, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
